// File: rtl/bus_mem_responder.sv
// ============================================================================
// Module   : bus_mem_responder
// Summary  : Responder (slave) for the CPU ce/rd/wr bus. Single-beat
//            requests are served from an internal register-array memory,
//            with programmable wait states and a one-cycle ack. The
//            optional even-parity path is enabled by BUS_RESP_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce,
    input  logic              rd,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_wr,
`ifdef BUS_RESP_PARITY_EN
    input  logic              data_wr_par,
    output logic              data_rd_par,
`endif
    output logic [DATA_W-1:0] data_rd,
    output logic              ack,
    output logic              busy,
    output logic              err
);

    localparam int              c_idx_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] c_depth = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      c_wait  = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_cnt;
    logic [3:0]          w_cnt_nxt;
    logic [c_idx_w-1:0]  r_addr;
    logic [DATA_W-1:0]   r_data_wr;
    logic                r_is_wr;
    logic [DATA_W-1:0]   r_data_rd;
    logic                r_err;
    logic [DATA_W-1:0]   r_mem [0:DEPTH-1];

    logic w_req;
    logic w_both;
    logic w_in_range;
    logic w_open;
    logic w_accept;
    logic w_err_req;
    logic w_access;
    logic w_par_bad;

    assign w_req      = ce & (rd ^ wr);
    assign w_both     = ce & rd & wr;
    assign w_in_range = ({1'b0, addr} < c_depth);
    // The edge that leaves DONE may already accept the next request.
    assign w_open     = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_accept   = w_open & w_req & w_in_range;
    assign w_err_req  = w_open & (w_both | (w_req & ~w_in_range));
    assign w_access   = (r_state == S_WAIT) && (r_cnt == 4'd0);

`ifdef BUS_RESP_PARITY_EN
    logic r_par_wr;
    logic r_par_rd;

    assign w_par_bad   = r_is_wr & ((^r_data_wr) ^ r_par_wr);
    assign data_rd_par = r_par_rd;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_par_rd <= 1'b0;
        end else begin
            if (w_accept) begin
                r_par_wr <= data_wr_par;
            end
            if (w_access && !r_is_wr) begin
                r_par_rd <= ^r_mem[r_addr];
            end
        end
    end
`else
    assign w_par_bad = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept) begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = c_wait;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_data_rd <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_req | (w_access & w_par_bad);
            if (w_accept) begin
                r_addr    <= addr[c_idx_w-1:0];
                r_data_wr <= data_wr;
                r_is_wr   <= wr;
            end
            if (w_access && !r_is_wr) begin
                r_data_rd <= r_mem[r_addr];
            end
        end
    end

    // Memory has no reset; a reset on the access edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!reset && w_access && r_is_wr && !w_par_bad) begin
            r_mem[r_addr] <= r_data_wr;
        end
    end

    assign data_rd = r_data_rd;
    assign ack     = (r_state == S_DONE);
    assign busy    = (r_state != S_IDLE);
    assign err     = r_err;

endmodule

`default_nettype wire

// File: tb/tb_bus_mem_responder.sv
// ============================================================================
// Module   : tb_bus_mem_responder
// Summary  : Directed bench for bus_mem_responder with a transaction-level
//            reference model compared every cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_mem_responder;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 128;
    localparam int WS     = 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              ce = 1'b0;
    logic              rd = 1'b0;
    logic              wr = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [DATA_W-1:0] data_wr = '0;
    logic              par_in = 1'b0;
    logic [DATA_W-1:0] data_rd;
    logic              ack;
    logic              busy;
    logic              err;
`ifdef BUS_RESP_PARITY_EN
    logic              data_rd_par;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    bus_mem_responder #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .WAIT_STATES(WS)
    ) dut (
        .clk(clk), .reset(reset), .ce(ce), .rd(rd), .wr(wr),
        .addr(addr), .data_wr(data_wr),
`ifdef BUS_RESP_PARITY_EN
        .data_wr_par(par_in), .data_rd_par(data_rd_par),
`endif
        .data_rd(data_rd), .ack(ack), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: an accepted request completes at a known edge.
    logic [DATA_W-1:0] m_mem [0:DEPTH-1];
    logic [DATA_W-1:0] m_data_rd;
    logic              m_ack, m_busy, m_err, m_valid;
    logic              m_active, m_wr, m_par;
    int                m_addr;
    logic [DATA_W-1:0] m_wdata;
    int                cyc = 0;
    int                m_ack_edge = 0;

    initial begin
        m_valid = 1'b0; m_active = 1'b0;
        m_ack = 1'b0; m_busy = 1'b0; m_err = 1'b0; m_data_rd = '0;
    end

    always @(posedge clk) begin
        logic free;
        cyc++;
        m_err = 1'b0;
        if (reset) begin
            m_valid = 1'b1; m_active = 1'b0;
            m_ack = 1'b0; m_busy = 1'b0; m_data_rd = '0;
        end else begin
            if (m_active && cyc == m_ack_edge) begin
                if (m_wr) begin
`ifdef BUS_RESP_PARITY_EN
                    if ((^m_wdata) != m_par) m_err = 1'b1;
                    else m_mem[m_addr] = m_wdata;
`else
                    m_mem[m_addr] = m_wdata;
`endif
                end else begin
                    m_data_rd = m_mem[m_addr];
                end
            end
            free = !m_active || (cyc > m_ack_edge);
            if (m_active && cyc > m_ack_edge) m_active = 1'b0;
            if (free && ce && (rd != wr)) begin
                if (int'(addr) < DEPTH) begin
                    m_active = 1'b1; m_ack_edge = cyc + 1 + WS;
                    m_addr = int'(addr); m_wdata = data_wr; m_wr = wr; m_par = par_in;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (free && ce && rd && wr) m_err = 1'b1;
            m_ack  = m_active && (cyc == m_ack_edge);
            m_busy = m_active;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("cyc_ack", {31'b0, ack}, {31'b0, m_ack});
            chk("cyc_busy", {31'b0, busy}, {31'b0, m_busy});
            chk("cyc_err", {31'b0, err}, {31'b0, m_err});
            chk("cyc_data_rd", {24'b0, data_rd}, {24'b0, m_data_rd});
`ifdef BUS_RESP_PARITY_EN
            chk("cyc_data_rd_par", {31'b0, data_rd_par}, {31'b0, ^m_data_rd});
`endif
        end
    end

    // Drive a one-cycle request; returns at the first negedge after acceptance.
    task automatic start(input logic r, input logic w, input logic [7:0] a,
                         input logic [7:0] d, input logic p);
        @(negedge clk);
        ce = 1'b1; rd = r; wr = w; addr = a; data_wr = d; par_in = p;
        @(negedge clk);
        ce = 1'b0; rd = 1'b0; wr = 1'b0; addr = 8'hEE; data_wr = 8'hEE;
    endtask

    // Latency counted in negedges from the drive negedge; busy checked on the way.
    task automatic wait_ack(output int lat, output logic busy_ok);
        lat = 1;
        busy_ok = busy;
        while (!ack && lat < 30) begin
            @(negedge clk);
            lat++;
            busy_ok = busy_ok & busy;
        end
        if (!ack) lat = -1;
        @(negedge clk);
    endtask

    task automatic xfer(input logic r, input logic w, input logic [7:0] a,
                        input logic [7:0] d, input logic p, output int lat, output logic busy_ok);
        start(r, w, a, d, p);
        wait_ack(lat, busy_ok);
    endtask

    initial begin
        int   lat;
        logic bok;
        int   acks;
        logic saw_err;

        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_ack", {31'b0, ack}, 32'd0);
        chk("reset_err", {31'b0, err}, 32'd0);
        chk("reset_data_rd", {24'b0, data_rd}, 32'h00);

        xfer(0, 1, 8'h11, 8'hAA, 0, lat, bok);
        chk("wr11_latency", lat, 32'd3);
        chk("wr11_busy", {31'b0, bok}, 32'd1);
        start(1, 0, 8'h11, 8'h00, 0);
        chk("rd11_err", {31'b0, err}, 32'd0);
        wait_ack(lat, bok);
        chk("rd11_latency", lat, 32'd3);
        chk("rd11_busy", {31'b0, bok}, 32'd1);
        chk("rd11_data", {24'b0, data_rd}, 32'hAA);

        xfer(0, 1, 8'h12, 8'hAB, 0, lat, bok);
        xfer(0, 1, 8'h13, 8'h0A, 0, lat, bok);
        xfer(1, 0, 8'h12, 8'h00, 0, lat, bok);
        chk("rd12_data", {24'b0, data_rd}, 32'hAB);
        xfer(1, 0, 8'h13, 8'h00, 0, lat, bok);
        chk("rd13_data", {24'b0, data_rd}, 32'h0A);
        xfer(0, 1, 8'h14, 8'h55, 0, lat, bok);
        chk("hold_after_wr14", {24'b0, data_rd}, 32'h0A);

        xfer(0, 1, 8'h20, 8'h77, 0, lat, bok);
        start(1, 1, 8'h20, 8'h00, 0);
        chk("both_err_pulse", {31'b0, err}, 32'd1);
        acks = 0; saw_err = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (ack) acks++;
            saw_err = saw_err | err;
        end
        chk("both_no_ack", acks, 32'd0);
        chk("both_err_one_cycle", {31'b0, saw_err}, 32'd0);
        xfer(1, 0, 8'h20, 8'h00, 0, lat, bok);
        chk("rd20_data", {24'b0, data_rd}, 32'h77);

        xfer(0, 1, 8'h30, 8'h5A, 0, lat, bok);
        start(1, 0, 8'h11, 8'h00, 0);
        ce = 1'b1; wr = 1'b1; addr = 8'h30; data_wr = 8'hFF;
        @(negedge clk);
        chk("busy_req_no_err", {31'b0, err}, 32'd0);
        ce = 1'b0; wr = 1'b0;
        acks = (ack) ? 1 : 0;
        repeat (8) begin
            @(negedge clk);
            if (ack) acks++;
        end
        chk("busy_single_ack", acks, 32'd1);
        chk("busy_rd11_data", {24'b0, data_rd}, 32'hAA);
        xfer(1, 0, 8'h30, 8'h00, 0, lat, bok);
        chk("rd30_unchanged", {24'b0, data_rd}, 32'h5A);

        xfer(0, 1, 8'h40, 8'h01, 0, lat, bok);
        start(0, 1, 8'h40, 8'h99, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_ack", {31'b0, ack}, 32'd0);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_data_rd", {24'b0, data_rd}, 32'h00);
        acks = 0;
        repeat (4) begin
            @(negedge clk);
            if (ack) acks++;
        end
        chk("abort_no_late_ack", acks, 32'd0);
        xfer(1, 0, 8'h40, 8'h00, 0, lat, bok);
        chk("rd40_old", {24'b0, data_rd}, 32'h01);

        start(1, 0, 8'h90, 8'h00, 0);
        chk("oor_err", {31'b0, err}, 32'd1);
        acks = 0;
        repeat (4) begin
            @(negedge clk);
            if (ack) acks++;
        end
        chk("oor_no_ack", acks, 32'd0);
        chk("oor_data_held", {24'b0, data_rd}, 32'h01);
        xfer(0, 1, 8'h7F, 8'hC3, 0, lat, bok);
        xfer(1, 0, 8'h7F, 8'h00, 0, lat, bok);
        chk("rd7f_top_word", {24'b0, data_rd}, 32'hC3);

`ifdef BUS_RESP_PARITY_EN
        xfer(0, 1, 8'h50, 8'h11, 0, lat, bok);
        start(0, 1, 8'h50, 8'h03, 1);
        wait_ack(lat, bok);
        chk("par_bad_latency", lat, 32'd3);
        xfer(1, 0, 8'h50, 8'h00, 0, lat, bok);
        chk("par_bad_mem_kept", {24'b0, data_rd}, 32'h11);
        chk("par_rd_par_odd", {31'b0, data_rd_par}, 32'd0);
        xfer(0, 1, 8'h50, 8'h03, 0, lat, bok);
        xfer(1, 0, 8'h50, 8'h00, 0, lat, bok);
        chk("par_good_data", {24'b0, data_rd}, 32'h03);
        chk("par_good_par", {31'b0, data_rd_par}, 32'd0);
        xfer(0, 1, 8'h51, 8'h07, 1, lat, bok);
        xfer(1, 0, 8'h51, 8'h00, 0, lat, bok);
        chk("par_odd_word", {31'b0, data_rd_par}, 32'd1);
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/bus_mem_responder.md
Name: bus_mem_responder

Overview:
- Synthesizable responder (slave) end of the CPU ce/rd/wr bus: accepts single-beat read and write requests from the CPU initiator and services them from an internal register-array memory.
- Latches the request on acceptance, so the initiator needs to drive ce/rd/wr/addr for only one cycle.
- Inserts a programmable number of wait states, then signals completion with a one-cycle ack.
- Replaces the behavioural memory model on the bus and serves as the memory for testbenches.

Parameters:
- ADDR_W, 8, address width.
- DATA_W, 8, data width.
- DEPTH, 256, number of words; must be at most 2**ADDR_W.
- WAIT_STATES, 1, extra cycles between acceptance and ack (0..15).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous active-high reset.
- ce  input  1  chip enable; qualifies rd/wr.
- rd  input  1  read request.
- wr  input  1  write request.
- addr  input  ADDR_W  request address.
- data_wr  input  DATA_W  write data.
- data_rd  output  DATA_W  read data; valid when ack is high, then held.
- ack  output  1  one-cycle completion pulse.
- busy  output  1  high while a request is in flight.
- err  output  1  one-cycle pulse for a protocol or address error.

Behaviour:
- Reset: one clock, synchronous, active-high; reset is sampled on the rising edge of clk.
  - On reset: state=IDLE, data_rd=0, ack=0, busy=0, err=0, wait counter=0.
  - Memory contents are not reset.
  - Reset mid-operation aborts the in-flight request: no memory update, no ack.
- States: IDLE, WAIT, DONE.
- IDLE, edge N, with ce=1 and exactly one of rd/wr high, and addr < DEPTH:
  - Latch addr, data_wr and the direction.
  - Load counter=WAIT_STATES.
  - Go to WAIT; busy=1 from edge N.
- IDLE with ce=1, rd=1 and wr=1:
  - No access; err pulses high for the cycle after edge N; stay IDLE.
- IDLE with ce=1, one of rd/wr high, and addr >= DEPTH:
  - err pulses; no access.
  - Reads in this case return nothing: data_rd is unchanged and there is no ack.
- IDLE with ce=1 and rd=wr=0: ignored.
- IDLE with ce=0: rd, wr, addr and data_wr are don't-care.
- WAIT:
  - While counter != 0: decrement on each edge.
  - At the edge where counter==0, perform the access:
    - Write: mem[addr_l] <= data_wr_l.
    - Read: data_rd <= mem[addr_l].
  - At that same edge, go to DONE and set ack=1.
- DONE: lasts one cycle with ack=1 and busy=1. The next edge returns to IDLE with ack=0 and busy=0.
- Latency: ack is high in the cycle following edge N+1+WAIT_STATES. With WAIT_STATES=0, ack is high after edge N+1.
- No back-to-back acceptance: the earliest next acceptance is the edge that leaves DONE. Throughput is one request per WAIT_STATES+2 cycles.
- Requests presented while busy=1 are ignored: not queued, no err.
- data_rd holds its last read value through writes and idle cycles.
- Read-after-write to the same address returns the new data.
- The bus inputs are sampled only at acceptance; changes during WAIT or DONE have no effect.

Optional Feature:
- Macro: BUS_RESP_PARITY_EN.
- When defined:
  - Adds input data_wr_par (1 bit) and output data_rd_par (1 bit). Parity is even over the data bits; the par bit is the XOR of the data.
  - data_wr_par is latched together with data_wr at acceptance.
  - On a write, if the XOR of data_wr_l and the latched parity bit is 1:
    - Memory is not updated.
    - The request still completes with ack; err pulses in the same cycle as ack.
  - On a read, data_rd_par = XOR of data_rd; it updates with data_rd and resets to 0.
- When not defined: the ports are absent, there is no parity checking, and write behaviour is unconditional.

Test Plan:
- Reset, then write addr 0x11 data 0xAA (WAIT_STATES=1), then read 0x11 -> ack 3 cycles after each acceptance edge; data_rd=0xAA on the read ack; busy high from acceptance to ack; err=0.
- Writes 0x12<-0xAB and 0x13<-0x0A, then read 0x12 and 0x13 -> data_rd=0xAB then 0x0A; data_rd stays 0x0A through a subsequent write of 0x55 to 0x14.
- ce=1 with rd=1 and wr=1 at addr 0x20, preceded by a write 0x20<-0x77 -> err pulses one cycle; no ack; read 0x20 returns 0x77.
- New request pulsed while busy=1 (write 0x30<-0xFF during WAIT of a read of 0x11) -> ignored; mem[0x30] unchanged; only one ack occurs.
- Assert reset during WAIT of a write 0x40<-0x99 after mem[0x40]=0x01 -> no ack, busy=0, data_rd=0; read 0x40 returns 0x01.
- BUS_RESP_PARITY_EN defined: write 0x50<-0x03 with par=1 (bad) -> ack with err, mem unchanged. Write 0x50<-0x03 with par=0 (good), then read -> data_rd=0x03, data_rd_par=0.
